// File: rtl/wb_dma_arbiter.sv
// -----------------------------------------------------------------------------
// wb_dma_arbiter
// Wishbone bus arbiter between the 1801VM1 processor module and NDMA DMA
// masters (disk/tape controllers). The CPU owns the bus by default. DMA
// masters are served round-robin, one tenure at a time. Every tenure is
// followed by a one-cycle TURN and a guaranteed CPU slot.
//
// Ports
//   clk_p      in   1         system clock, rising edge
//   dclo       in   1         synchronous reset, active high
//   cpu_stb_i  in   1         CPU local strobe; the bus is never taken mid-cycle
//   cpu_gnt_o  out  1         registered bus grant to the CPU
//   dma_req_i  in   NDMA      per-master bus request, held for the whole tenure
//   dma_gnt_o  out  NDMA      registered per-master grant, one-hot or zero
//   dma_stb_i  in   NDMA      per-master strobe
//   dma_we_i   in   NDMA      per-master write enable
//   dma_sel_i  in   2*NDMA    per-master byte selects, master i at [2i+1:2i]
//   dma_adr_i  in   16*NDMA   per-master address, master i at [16i+15:16i]
//   dma_dat_i  in   16*NDMA   per-master write data
//   dma_ack_o  out  NDMA      per-master ack (bus ack or watchdog ack)
//   bus_stb_o  out  1         shared-bus strobe (DMA side)
//   bus_we_o   out  1         shared-bus write enable
//   bus_sel_o  out  2         shared-bus byte selects
//   bus_adr_o  out  16        shared-bus address
//   bus_dat_o  out  16        shared-bus write data
//   bus_ack_i  in   1         shared-bus ack
//   timeout_o  out  1         one-cycle pulse when the no-ack watchdog expires
// -----------------------------------------------------------------------------
module wb_dma_arbiter #(
  parameter int NDMA      = 2,
  parameter int CPU_SLOT  = 4,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk_p,
  input  logic                 dclo,
  input  logic                 cpu_stb_i,
  output logic                 cpu_gnt_o,
  input  logic [NDMA-1:0]      dma_req_i,
  output logic [NDMA-1:0]      dma_gnt_o,
  input  logic [NDMA-1:0]      dma_stb_i,
  input  logic [NDMA-1:0]      dma_we_i,
  input  logic [2*NDMA-1:0]    dma_sel_i,
  input  logic [16*NDMA-1:0]   dma_adr_i,
  input  logic [16*NDMA-1:0]   dma_dat_i,
  output logic [NDMA-1:0]      dma_ack_o,
  output logic                 bus_stb_o,
  output logic                 bus_we_o,
  output logic [1:0]           bus_sel_o,
  output logic [15:0]          bus_adr_o,
  output logic [15:0]          bus_dat_o,
  input  logic                 bus_ack_i,
  output logic                 timeout_o
);

  localparam int IW = (NDMA > 1) ? $clog2(NDMA) : 1;

  typedef enum logic [1:0] {
    ST_CPU  = 2'd0,
    ST_DMA  = 2'd1,
    ST_TURN = 2'd2
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_win;
  logic [IW-1:0]   r_ptr;
  logic [7:0]      r_slot;
  logic [7:0]      r_burst;
  logic [7:0]      r_wd;
  logic            r_cpu_gnt;
  logic [NDMA-1:0] r_dma_gnt;

  logic [IW-1:0]   w_pick;
  logic [7:0]      w_slot_dec;
  logic            w_leave_cpu;
  logic            w_stb;
  logic            w_req_w;
  logic            w_fire;
  logic            w_ack_w;

  // First requester strictly after ptr, wrapping; ptr itself has lowest priority.
  function automatic logic [IW-1:0] rr_pick(input logic [NDMA-1:0] req,
                                            input logic [IW-1:0]   ptr);
    logic [IW-1:0] pick;
    int            idx;
    pick = ptr;
    // Scan from farthest to nearest so the nearest requester overwrites last.
    for (int k = NDMA; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NDMA;
      if (req[idx]) begin
        pick = IW'(idx);
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  assign w_pick      = rr_pick(dma_req_i, r_ptr);
  // The CPU's last slot cycle is the one in which the counter reaches zero.
  assign w_slot_dec  = (r_slot != 8'd0) ? (r_slot - 8'd1) : 8'd0;
  assign w_leave_cpu = (|dma_req_i) && (w_slot_dec == 8'd0) && !cpu_stb_i;
  assign w_stb       = (r_state == ST_DMA) && dma_stb_i[r_win];
  assign w_req_w     = dma_req_i[r_win];
  // Watchdog fires only when no real ack arrives in the expiry cycle.
  assign w_fire      = w_stb && !bus_ack_i && (r_wd == 8'(TIMEOUT));
  assign w_ack_w     = (r_state == ST_DMA) && (bus_ack_i || w_fire);

  assign cpu_gnt_o   = r_cpu_gnt;
  assign dma_gnt_o   = r_dma_gnt;
  assign timeout_o   = w_fire;

  // Route the granted master onto the shared bus; everything is zero outside DMA.
  always_comb begin
    bus_stb_o = 1'b0;
    bus_we_o  = 1'b0;
    bus_sel_o = 2'b00;
    bus_adr_o = 16'h0000;
    bus_dat_o = 16'h0000;
    if (r_state == ST_DMA) begin
      bus_stb_o = dma_stb_i[r_win];
      bus_we_o  = dma_we_i[r_win];
      bus_sel_o = dma_sel_i[{r_win, 1'b0} +: 2];
      bus_adr_o = dma_adr_i[{r_win, 4'b0000} +: 16];
      bus_dat_o = dma_dat_i[{r_win, 4'b0000} +: 16];
    end else begin
      bus_stb_o = 1'b0;
    end
  end

  // Return the ack only to the granted master.
  always_comb begin
    dma_ack_o = {NDMA{1'b0}};
    if (w_ack_w) begin
      dma_ack_o[r_win] = 1'b1;
    end else begin
      dma_ack_o = {NDMA{1'b0}};
    end
  end

  // Arbitration FSM with slot, burst and watchdog counters.
  always_ff @(posedge clk_p) begin
    if (dclo) begin
      r_state   <= ST_CPU;
      r_cpu_gnt <= 1'b1;
      r_dma_gnt <= {NDMA{1'b0}};
      r_win     <= {IW{1'b0}};
      r_ptr     <= IW'(NDMA - 1);
      r_slot    <= 8'd0;
      r_burst   <= 8'd0;
      r_wd      <= 8'd0;
    end else begin
      case (r_state)
        ST_CPU: begin
          r_slot <= w_slot_dec;
          if (w_leave_cpu) begin
            r_state   <= ST_DMA;
            r_win     <= w_pick;
            r_ptr     <= w_pick;
            r_cpu_gnt <= 1'b0;
            r_dma_gnt <= {{(NDMA-1){1'b0}}, 1'b1} << w_pick;
            r_burst   <= 8'd0;
            r_wd      <= 8'd0;
          end
        end
        ST_DMA: begin
          if (w_ack_w && (r_burst != 8'hFF)) begin
            r_burst <= r_burst + 8'd1;
          end
          if (w_fire || bus_ack_i) begin
            r_wd <= 8'd0;
          end else if (w_stb) begin
            r_wd <= r_wd + 8'd1;
          end
          // Release only between transfers, so a dropped request still gets its ack.
          if (!w_stb && (!w_req_w || (r_burst == 8'(MAX_BURST)))) begin
            r_state   <= ST_TURN;
            r_dma_gnt <= {NDMA{1'b0}};
          end
        end
        ST_TURN: begin
          r_state   <= ST_CPU;
          r_cpu_gnt <= 1'b1;
          r_slot    <= 8'(CPU_SLOT);
          r_burst   <= 8'd0;
          r_wd      <= 8'd0;
        end
        default: begin
          r_state   <= ST_CPU;
          r_cpu_gnt <= 1'b1;
          r_dma_gnt <= {NDMA{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_dma_arbiter.sv
module tb_wb_dma_arbiter;

  localparam int NDMA      = 2;
  localparam int CPU_SLOT  = 4;
  localparam int MAX_BURST = 4;
  localparam int TIMEOUT   = 16;

  logic        clk_p = 1'b0;
  logic        dclo  = 1'b1;
  logic        cpu_stb_i = 1'b0;
  logic        cpu_gnt_o;
  logic [1:0]  req = 2'b00;
  logic [1:0]  stb = 2'b00;
  logic [1:0]  we  = 2'b00;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0;
  logic [31:0] dat = 32'h0;
  logic [1:0]  dma_gnt_o;
  logic [1:0]  dma_ack_o;
  logic        bus_stb_o, bus_we_o, bus_ack_i, timeout_o;
  logic [1:0]  bus_sel_o;
  logic [15:0] bus_adr_o, bus_dat_o;
  logic        auto_ack = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  // Expected grant sequence: grant vector and CPU cycles before it (-1 = any).
  typedef struct {
    logic [1:0] gnt;
    int         cpu;
  } gexp_t;
  gexp_t sb_q[$];

  logic [1:0] prev_gnt = 2'b00;
  int         cpu_run  = 0;

  wb_dma_arbiter #(
    .NDMA(NDMA), .CPU_SLOT(CPU_SLOT), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_p(clk_p), .dclo(dclo), .cpu_stb_i(cpu_stb_i), .cpu_gnt_o(cpu_gnt_o),
    .dma_req_i(req), .dma_gnt_o(dma_gnt_o), .dma_stb_i(stb), .dma_we_i(we),
    .dma_sel_i(sel), .dma_adr_i(adr), .dma_dat_i(dat), .dma_ack_o(dma_ack_o),
    .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_adr_o(bus_adr_o), .bus_dat_o(bus_dat_o), .bus_ack_i(bus_ack_i),
    .timeout_o(timeout_o)
  );

  // Zero-wait slave, or a dead slave when auto_ack is low.
  assign bus_ack_i = auto_ack & bus_stb_o;

  always #5 clk_p = ~clk_p;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Grant monitor: pops the scoreboard on every new DMA grant.
  always @(negedge clk_p) begin
    if (dclo) begin
      prev_gnt <= 2'b00;
      cpu_run  <= 0;
    end else begin
      if ((dma_gnt_o != 2'b00) && (prev_gnt == 2'b00)) begin
        if (sb_q.size() == 0) begin
          check_eq("gnt_unexpected", dma_gnt_o, 2'b00);
        end else begin
          check_eq("gnt_order", dma_gnt_o, sb_q[0].gnt);
          if (sb_q[0].cpu >= 0) check_eq("cpu_slot_len", cpu_run, sb_q[0].cpu);
          void'(sb_q.pop_front());
        end
      end
      if ((dma_gnt_o == 2'b00) && (prev_gnt != 2'b00)) check_eq("turn_cycle", cpu_gnt_o, 1'b0);
      cpu_run  <= cpu_gnt_o ? cpu_run + 1 : 0;
      prev_gnt <= dma_gnt_o;
    end
  end

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] g, input int c);
    gexp_t e;
    e.gnt = g;
    e.cpu = c;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    dclo = 1'b1; req = 2'b00; stb = 2'b00; cpu_stb_i = 1'b0; auto_ack = 1'b1;
    tick();
    tick();
    @(negedge clk_p);
    check_eq("rst_cpu_gnt", cpu_gnt_o, 1'b1);
    check_eq("rst_dma_gnt", dma_gnt_o, 2'b00);
    check_eq("rst_bus_stb", bus_stb_o, 1'b0);
    check_eq("rst_dma_ack", dma_ack_o, 2'b00);
    check_eq("rst_timeout", timeout_o, 1'b0);
    check_eq("rst_bus_adr", bus_adr_o, 16'h0000);
    tick();
    dclo = 1'b0;
  endtask

  task automatic wait_gnt(input int m);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_p);
      if (dma_gnt_o[m]) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("gnt_wait", ok, 1'b1);
    tick();
  endtask

  // One transfer from master m; drives the other master with different values.
  task automatic xfer(input int m, input logic [15:0] a, input logic [15:0] d, input logic drop);
    logic       got;
    logic [1:0] s;
    s = (m == 0) ? 2'b01 : 2'b10;
    adr = {~a, ~a};  adr[16*m +: 16] = a;
    dat = {~d, ~d};  dat[16*m +: 16] = d;
    sel = 4'hF;      sel[2*m +: 2]   = s;
    we  = {~a[0], ~a[0]}; we[m] = a[0];
    stb[m] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_p);
      if (dma_ack_o[m]) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check_eq("ack_wait", got, 1'b1);
    if (got) begin
      check_eq("bus_stb", bus_stb_o, 1'b1);
      check_eq("bus_adr", bus_adr_o, a);
      check_eq("bus_dat", bus_dat_o, d);
      check_eq("bus_sel", bus_sel_o, s);
      check_eq("bus_we", bus_we_o, a[0]);
    end
    tick();
    stb[m] = 1'b0;
    if (drop) req[m] = 1'b0;
    tick();
  endtask

  initial begin
    int   bad;
    int   n;
    logic got;

    // 1: idle after reset
    do_reset();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_p);
      if ((cpu_gnt_o !== 1'b1) || (dma_gnt_o !== 2'b00) || (bus_stb_o !== 1'b0)) bad++;
      tick();
    end
    check_eq("idle_bad_cycles", bad, 0);

    // 2: CPU never cut mid-transaction
    do_reset();
    push_exp(2'b01, -1);
    cpu_stb_i = 1'b1;
    req = 2'b01;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_p);
      if ((cpu_gnt_o !== 1'b1) || (dma_gnt_o !== 2'b00)) bad++;
      tick();
    end
    check_eq("cpu_hold_bad_cycles", bad, 0);
    cpu_stb_i = 1'b0;
    @(negedge clk_p);
    check_eq("cpu_hold_last", cpu_gnt_o, 1'b1);
    tick();
    @(negedge clk_p);
    check_eq("handover_cpu_gnt", cpu_gnt_o, 1'b0);
    check_eq("handover_dma_gnt", dma_gnt_o, 2'b01);
    tick();
    xfer(0, 16'h1000, 16'hBEEF, 1'b1);

    // 3: round robin with both requesting
    do_reset();
    push_exp(2'b01, -1);
    push_exp(2'b10, CPU_SLOT);
    push_exp(2'b01, CPU_SLOT);
    req = 2'b11;
    wait_gnt(0);
    xfer(0, 16'h1234, 16'hA5A5, 1'b1);
    req[0] = 1'b1;
    wait_gnt(1);
    xfer(1, 16'h5679, 16'h5A5A, 1'b1);
    wait_gnt(0);
    xfer(0, 16'h2222, 16'h0F0F, 1'b1);
    req = 2'b00;
    tick();

    // 4: burst limit forces release
    do_reset();
    push_exp(2'b01, -1);
    push_exp(2'b01, CPU_SLOT);
    req = 2'b01;
    wait_gnt(0);
    for (int k = 0; k < MAX_BURST; k++) begin
      xfer(0, 16'h0100 + 16'(k), 16'hC000 + 16'(k), 1'b0);
    end
    @(negedge clk_p);
    check_eq("burst_release_gnt", dma_gnt_o, 2'b00);
    check_eq("burst_release_cpu", cpu_gnt_o, 1'b0);
    wait_gnt(0);
    xfer(0, 16'h0201, 16'hD001, 1'b0);
    xfer(0, 16'h0202, 16'hD002, 1'b1);
    tick();

    // 5: watchdog on a dead slave
    do_reset();
    push_exp(2'b01, -1);
    auto_ack = 1'b0;
    req = 2'b01;
    wait_gnt(0);
    adr = 32'h0000_3000;
    stb[0] = 1'b1;
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_p);
      if (dma_ack_o[0]) begin
        got = 1'b1;
        break;
      end
      n++;
      tick();
    end
    check_eq("wd_ack_seen", got, 1'b1);
    check_eq("wd_cycles", n, TIMEOUT);
    check_eq("wd_timeout_pulse", timeout_o, 1'b1);
    check_eq("wd_ack_vec", dma_ack_o, 2'b01);
    tick();
    stb = 2'b00;
    req = 2'b00;
    @(negedge clk_p);
    check_eq("wd_timeout_after", timeout_o, 1'b0);
    check_eq("wd_ack_after", dma_ack_o, 2'b00);
    tick();
    tick();

    // 6: reset mid-tenure
    do_reset();
    push_exp(2'b01, -1);
    auto_ack = 1'b0;
    req = 2'b01;
    wait_gnt(0);
    stb[0] = 1'b1;
    tick();
    @(negedge clk_p);
    check_eq("pre_rst_bus_stb", bus_stb_o, 1'b1);
    tick();
    dclo = 1'b1;
    @(negedge clk_p);
    tick();
    @(negedge clk_p);
    check_eq("midrst_cpu_gnt", cpu_gnt_o, 1'b1);
    check_eq("midrst_dma_gnt", dma_gnt_o, 2'b00);
    check_eq("midrst_bus_stb", bus_stb_o, 1'b0);
    check_eq("midrst_dma_ack", dma_ack_o, 2'b00);
    stb = 2'b00;
    req = 2'b00;
    tick();
    dclo = 1'b0;
    auto_ack = 1'b1;
    tick();

    check_eq("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
